// File: rtl/gameshow_host_ctrl.sv
// rtl/gameshow_host_ctrl.sv - gameshow host controller: winner resolve, answer countdown, buzzer clear
// Optional per-question mask of wrong players: define GAMESHOW_WRONG_MASK_EN.
module gameshow_host_ctrl #(
  parameter int N_PLAYERS       = 6,
  parameter int PRESCALE_CYCLES = 10000,
  parameter int ANSWER_SECS     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] lockout,
  input  logic                 host_start,
  input  logic                 host_correct,
  input  logic                 host_wrong,
  output logic                 buzzer_clr,
  output logic                 winner_valid,
  output logic [2:0]           winner_id,
  output logic                 tie,
  output logic [3:0]           seconds_left,
  output logic                 timeout
);

  localparam int PW = (PRESCALE_CYCLES > 1) ? $clog2(PRESCALE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_CYCLES - 1);
  localparam logic [3:0]    SECS_INIT  = 4'(ANSWER_SECS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2,
    S_REARM  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           hist_q, hist_d;
  logic [N_PLAYERS-1:0] mask_q, mask_d;
  logic [2:0]           win_q, win_d;
  logic                 tie_q, tie_d;
  logic [3:0]           secs_q, secs_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 timeout_q, timeout_d;
  logic                 clr_pulse_q, clr_pulse_d;

  logic                 start_edge, correct_edge, wrong_edge;
  logic [N_PLAYERS-1:0] eff;
  logic [2:0]           win_idx;
  logic                 multi_buzz;
  logic                 presc_last;
  logic                 expire;

  assign start_edge   = host_start   & ~hist_q[0];
  assign correct_edge = host_correct & ~hist_q[1];
  assign wrong_edge   = host_wrong   & ~hist_q[2];

  assign eff        = lockout & ~mask_q;
  assign multi_buzz = (eff & (eff - 1'b1)) != '0;
  assign presc_last = presc_q == PRESC_LAST;
  assign expire     = presc_last && (secs_q == 4'd1);

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    win_idx = 3'd0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (eff[i]) win_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hist_q      <= '0;
      mask_q      <= '0;
      win_q       <= '0;
      tie_q       <= 1'b0;
      secs_q      <= '0;
      presc_q     <= '0;
      timeout_q   <= 1'b0;
      clr_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      mask_q      <= mask_d;
      win_q       <= win_d;
      tie_q       <= tie_d;
      secs_q      <= secs_d;
      presc_q     <= presc_d;
      timeout_q   <= timeout_d;
      clr_pulse_q <= clr_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = {host_wrong, host_correct, host_start};
    mask_d      = mask_q;
    win_d       = win_q;
    tie_d       = tie_q;
    secs_d      = secs_q;
    presc_d     = presc_q;
    timeout_d   = 1'b0;
    clr_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_ARMED;
          mask_d  = '0;
        end
      end

      S_ARMED: begin
        if (eff != '0) begin
          state_d = S_ANSWER;
          win_d   = win_idx;
          tie_d   = multi_buzz;
          secs_d  = SECS_INIT;
          presc_d = '0;
        end else if ((lockout != '0) && !clr_pulse_q) begin
          // Only masked players buzzed: flush the latch for one cycle and keep waiting.
          clr_pulse_d = 1'b1;
        end
      end

      S_ANSWER: begin
        presc_d = presc_last ? '0 : presc_q + 1'b1;
        if (presc_last) secs_d = secs_q - 4'd1;
        if (correct_edge) begin
          state_d = S_IDLE;
          secs_d  = '0;
          tie_d   = 1'b0;
        end else if (wrong_edge || expire) begin
          state_d   = S_REARM;
          secs_d    = '0;
          tie_d     = 1'b0;
          timeout_d = !wrong_edge;
`ifdef GAMESHOW_WRONG_MASK_EN
          mask_d    = mask_q | (N_PLAYERS'(1) << win_q);
`else
          mask_d    = '0;
`endif
        end
      end

      S_REARM: begin
        state_d = (&mask_q) ? S_IDLE : S_ARMED;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign buzzer_clr   = (state_q == S_IDLE) || (state_q == S_REARM) || clr_pulse_q;
  assign winner_valid = state_q == S_ANSWER;
  assign winner_id    = win_q;
  assign tie          = tie_q;
  assign seconds_left = secs_q;
  assign timeout      = timeout_q;

endmodule
